// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port owner: post-reset clear pass, then round-robin writeback arbitration
module regfile_wb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int CLEAR_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic [DATA_W-1:0]         wdata,
    output logic                      init_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                init_done_q, init_done_d;

    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      scan_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Scan from rr_ptr upward with wrap; the extra bit keeps ptr+offset from overflowing.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (!rst && state_q == ST_RUN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                    scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
                end
                if (!grant_vld && req_valid[scan_idx[PTR_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == PTR_W'(j)) begin
                sel_addr = req_addr[j*ADDR_W +: ADDR_W];
                sel_data = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                we_d      = 1'b1;
                waddr_d   = clr_cnt_q;
                wdata_d   = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(REG_NUM-1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (grant_vld) begin
                    rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                    // $0 is hardwired: accept the request but suppress the write.
                    if (sel_addr != '0) begin
                        we_d    = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= ADDR_W'(1);
            rr_ptr_q    <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= (CLEAR_EN == 0);
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - bench for regfile_wb_arbiter: vector table, clear/reset sequences, random run vs model
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr  = '0;
    logic [N*DW-1:0]   req_data  = '0;
    logic [N-1:0]      req_ready;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              init_done;

    regfile_wb_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .REG_NUM(32), .CLEAR_EN(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic [N-1:0]    exp_ready;
        logic            exp_we;
        logic [AW-1:0]   exp_waddr;
        logic [DW-1:0]   exp_wdata;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] rdy, input logic w,
                                input logic [4:0] wa, input logic [31:0] wd);
        vec_t r;
        r.valid     = v;
        r.addr      = {a2, a1, a0};
        r.data      = {d2, d1, d0};
        r.exp_ready = rdy;
        r.exp_we    = w;
        r.exp_waddr = wa;
        r.exp_wdata = wd;
        return r;
    endfunction

    vec_t tbl [15];

    // Behavioural model state for the random phase.
    logic          vv [N];
    logic [AW-1:0] va [N];
    logic [DW-1:0] vd [N];
    int            m_ptr   = 0;
    bit            m_clear = 1'b1;
    int            m_cnt   = 1;
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_init  = 1'b0;

    function automatic int model_grant();
        if (rst || m_clear) return -1;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (rst) begin
            m_clear = 1'b1; m_cnt = 1; m_ptr = 0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_init = 1'b0;
        end else if (m_clear) begin
            m_we = 1'b1; m_waddr = AW'(m_cnt); m_wdata = '0;
            if (m_cnt == 31) begin
                m_clear = 1'b0; m_init = 1'b1;
            end
            m_cnt++;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            m_we  = (va[g] != '0);
            if (m_we) begin
                m_waddr = va[g];
                m_wdata = vd[g];
            end
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = vv[i];
            req_addr[i*AW +: AW]  = va[i];
            req_data[i*DW +: DW]  = vd[i];
        end
    endtask

    task automatic run_clear(input string tag);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_we%0d", tag, k), 64'(we), 64'(1));
            chk($sformatf("%s_waddr%0d", tag, k), 64'(waddr), 64'(k));
            chk($sformatf("%s_wdata%0d", tag, k), 64'(wdata), 64'(0));
            chk($sformatf("%s_init%0d", tag, k), 64'(init_done), 64'(k == 31));
            if (k <= 30) chk($sformatf("%s_ready%0d", tag, k), 64'(req_ready), 64'(0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [N-1:0] exp_r;

        tbl[0]  = mk(3'b111, 5, 6, 7, 32'hA0, 32'hB1, 32'hC2, 3'b001, 1, 5, 32'hA0);
        tbl[1]  = mk(3'b110, 5, 6, 7, 32'hA0, 32'hB1, 32'hC2, 3'b010, 1, 6, 32'hB1);
        tbl[2]  = mk(3'b100, 5, 6, 7, 32'hA0, 32'hB1, 32'hC2, 3'b100, 1, 7, 32'hC2);
        tbl[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 7, 32'hC2);
        tbl[4]  = mk(3'b010, 0, 9, 0, 0, 32'h11, 0, 3'b010, 1, 9, 32'h11);
        tbl[5]  = mk(3'b101, 3, 0, 4, 32'h33, 0, 32'h44, 3'b100, 1, 4, 32'h44);
        tbl[6]  = mk(3'b001, 3, 0, 0, 32'h33, 0, 0, 3'b001, 1, 3, 32'h33);
        tbl[7]  = mk(3'b100, 0, 0, 8, 0, 0, 32'h88, 3'b100, 1, 8, 32'h88);
        tbl[8]  = mk(3'b011, 0, 10, 0, 32'hFFFFFFFF, 32'h1010, 0, 3'b001, 0, 8, 32'h88);
        tbl[9]  = mk(3'b010, 0, 10, 0, 0, 32'h1010, 0, 3'b010, 1, 10, 32'h1010);
        tbl[10] = mk(3'b100, 0, 0, 1, 0, 0, 32'hD1, 3'b100, 1, 1, 32'hD1);
        tbl[11] = mk(3'b100, 0, 0, 2, 0, 0, 32'hD2, 3'b100, 1, 2, 32'hD2);
        tbl[12] = mk(3'b100, 0, 0, 3, 0, 0, 32'hD3, 3'b100, 1, 3, 32'hD3);
        tbl[13] = mk(3'b100, 0, 0, 4, 0, 0, 32'hD4, 3'b100, 1, 4, 32'hD4);
        tbl[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4, 32'hD4);

        // Reset held two cycles with every requester pending.
        rst       = 1'b1;
        req_valid = tbl[0].valid;
        req_addr  = tbl[0].addr;
        req_data  = tbl[0].data;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_waddr", 64'(waddr), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_init", 64'(init_done), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        run_clear("clr");

        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].valid;
            req_addr  = tbl[i].addr;
            req_data  = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_we", i), 64'(we), 64'(tbl[i].exp_we));
            chk($sformatf("tbl%0d_waddr", i), 64'(waddr), 64'(tbl[i].exp_waddr));
            chk($sformatf("tbl%0d_wdata", i), 64'(wdata), 64'(tbl[i].exp_wdata));
        end

        // Reset in the middle of a clear pass, when waddr=10 is on the port.
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_waddr10", 64'(waddr), 64'(10));
        rst = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("mid_rst_we", 64'(we), 64'(0));
        chk("mid_rst_init", 64'(init_done), 64'(0));
        req_valid = '0;
        rst = 1'b0;
        run_clear("rclr");

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < N; i++) begin
            vv[i] = 1'b0; va[i] = '0; vd[i] = '0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vv[i] && $urandom_range(0, 3) != 0) begin
                    vv[i] = 1'b1;
                    va[i] = AW'($urandom_range(0, 31));
                    vd[i] = $urandom;
                end
            end
            rst = (c < 2) || ($urandom_range(0, 299) == 0);
            drive();
            #1;
            g = model_grant();
            exp_r = '0;
            if (g >= 0) exp_r[g] = 1'b1;
            chk($sformatf("rnd%0d_ready", c), 64'(req_ready), 64'(exp_r));
            @(posedge clk);
            model_update(g);
            if (g >= 0) vv[g] = 1'b0;
            #1;
            chk($sformatf("rnd%0d_we", c), 64'(we), 64'(m_we));
            chk($sformatf("rnd%0d_waddr", c), 64'(waddr), 64'(m_waddr));
            chk($sformatf("rnd%0d_wdata", c), 64'(wdata), 64'(m_wdata));
            chk($sformatf("rnd%0d_init", c), 64'(init_done), 64'(m_init));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 general-purpose register file.
- After reset, sequences a clear pass that writes zero to registers 1..REG_NUM-1. The register file array has no reset, so this pass is required.
- After the clear pass, shares the write port among NUM_REQ writeback requesters (e.g. ALU pipe, load unit, multi-cycle mul/div) with round-robin arbitration and a valid/ready handshake.
- Sits between the writeback sources and the register file's we/waddr/wdata inputs.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- REG_NUM, 32, number of registers (2**ADDR_W)
- CLEAR_EN, 1, 1 = run clear pass after reset; 0 = enter RUN directly

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  requester i has a pending write
- req_addr  in  NUM_REQ*ADDR_W  destination register; slice i is requester i
- req_data  in  NUM_REQ*DATA_W  write data; slice i is requester i
- req_ready  out  NUM_REQ  grant; combinational; at most one bit high
- we  out  1  register file write enable, registered
- waddr  out  ADDR_W  register file write address, registered
- wdata  out  DATA_W  register file write data, registered
- init_done  out  1  high once the clear pass is complete, registered

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=CLEAR (RUN if CLEAR_EN=0), clr_cnt<=1, rr_ptr<=0.
  - we<=0, waddr<=0, wdata<=0.
  - init_done<=0 (1 if CLEAR_EN=0).
  - req_ready is 0 while rst=1.
- Reset mid-operation:
  - Aborts a clear pass or arbitration immediately.
  - Ungranted requests are not written.
  - The clear pass restarts from register 1.
- CLEAR state, each edge with rst=0:
  - we<=1, waddr<=clr_cnt, wdata<=0, clr_cnt<=clr_cnt+1.
  - When clr_cnt==REG_NUM-1 is issued: state<=RUN, init_done<=1.
  - Exactly REG_NUM-1 writes; register 0 is never addressed.
  - waddr=k is visible after the k-th edge following reset release.
  - init_done rises together with waddr=REG_NUM-1.
  - req_ready=0 throughout CLEAR.
- RUN state, arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending with wrap-around.
  - The first valid index g gets req_ready[g]=1; all other ready bits are 0.
  - If no request is valid, all ready bits are 0.
- Handshake:
  - A transfer occurs when req_valid[g]&req_ready[g] at an edge.
  - Requesters hold valid/addr/data stable until their transfer.
  - Valid may not be withdrawn before the transfer; this is a protocol violation, behaviour undefined.
- On a transfer at edge E:
  - rr_ptr<=(g+1) mod NUM_REQ.
  - we<=1, waddr<=req_addr[g], wdata<=req_data[g], visible after E.
  - Latency from accept to the register file write: 1 cycle.
- Address-zero writes: if req_addr[g]==0, the request is still accepted (ready=1, pointer advances) but we<=0. The write is dropped because $0 is hardwired to zero.
- No transfer at an edge: we<=0; waddr and wdata hold their previous values.
- Throughput: one write per cycle. A lone requester with continuous valid is granted every cycle.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate strictly 0,1,...,NUM_REQ-1,0...
- No ordering or merging between requesters writing the same address; the later grant wins in the register file.
- rr_ptr does not change in cycles without a transfer.

Test Plan:
- Clear sequence: hold rst for 2 cycles, then release with all req_valid=1 -> we=1 with waddr=1..31 on consecutive cycles, wdata=0; req_ready=0 throughout; init_done=1 coincident with waddr=31; first req_ready appears on the following cycle.
- Round-robin contention: after init, req_valid=3'b111 with addrs 5,6,7 and data A0,B1,C2, each dropping valid after its transfer -> grants 0,1,2 on consecutive cycles; port shows (5,A0),(6,B1),(7,C2), each one cycle after its grant.
- Pointer rotation: after a grant to requester 1, assert valid on 0 and 2 together -> requester 2 is granted first, then requester 0.
- Zero address: requester 0 writes addr=0, data=FFFFFFFF -> req_ready[0]=1 for one cycle; we stays 0; next grant goes to requester 1 if it is valid.
- Reset mid-clear: assert rst for one cycle when waddr=10 is on the port -> we=0 during reset; clear restarts at waddr=1; init_done is reached 31 cycles after release.
- Back-to-back single requester: only requester 2 valid for 4 cycles with addrs 1..4 -> ready is high every cycle; we=1 for 4 consecutive cycles with waddr 1,2,3,4.
